// File: rtl/trd_pkg.sv
// Shared thread-context types for fetch, decode and the thread scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package trd_pkg;

  localparam int NUM_TRD = 8;
  localparam int TRD_W   = $clog2(NUM_TRD);

  // Thread ID carried alongside instructions from fetch into decode
  typedef logic [TRD_W-1:0] trd_id_t;

  // Lifecycle of one hardware thread context
  typedef enum logic [1:0] {
    OFF     = 2'd0,
    READY   = 2'd1,
    COOL    = 2'd2,
    BLOCKED = 2'd3
  } trd_state_t;

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: grants the first requester after i_ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether a grant is consumed.
module rr_arb #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic         o_gnt_vld,
  output logic [W-1:0] o_gnt_idx
);

  logic [W-1:0] w_idx;

  // Scan offsets from farthest to nearest so the nearest requester after the pointer wins;
  // offset N wraps to the pointer itself (N is a power of two)
  always_comb begin
    o_gnt_vld = 1'b0;
    o_gnt_idx = '0;
    w_idx     = '0;
    for (int k = N; k >= 1; k--) begin
      w_idx = i_ptr + W'(k);
      if (i_req[w_idx]) begin
        o_gnt_vld = 1'b1;
        o_gnt_idx = w_idx;
      end
    end
  end

endmodule

// File: rtl/trd_sched.sv
// Per-cycle thread scheduler: tracks thread lifecycle and picks one eligible thread round-robin.
// Latency: events at edge k affect eligibility at edge k+1; the pick is registered (1 cycle).
// Backpressure: stall freezes issue outputs and pointer; cooldown counters keep running.
module trd_sched
  import trd_pkg::*;
#(
  parameter int GAP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               spawn_vld,
  input  logic [TRD_W-1:0]   spawn_trd,
  input  logic               kill_vld,
  input  logic [TRD_W-1:0]   kill_trd,
  input  logic               block_vld,
  input  logic [TRD_W-1:0]   block_trd,
  input  logic               wake_vld,
  input  logic [TRD_W-1:0]   wake_trd,
  output logic               issue_vld,
  output logic [TRD_W-1:0]   issue_trd,
  output logic [NUM_TRD-1:0] active_mask,
  output logic               idle
);

  localparam int               CNT_W     = $clog2(GAP + 1);
  localparam logic [CNT_W-1:0] COOL_INIT = CNT_W'(GAP - 1);

  logic [NUM_TRD-1:0] w_elig;
  logic [NUM_TRD-1:0] w_active_nxt;
  logic               w_gnt_vld;
  logic [TRD_W-1:0]   w_gnt_idx;
  logic               w_issue;
  logic               w_drop_held;

  logic               r_issue_vld;
  logic [TRD_W-1:0]   r_issue_trd;
  logic [TRD_W-1:0]   r_ptr;
  logic [NUM_TRD-1:0] r_active;
  logic               r_idle;

  assign w_issue = !stall && w_gnt_vld;

  // A held issue must not keep advertising a thread that is being killed or blocked
  assign w_drop_held = (kill_vld && (kill_trd == r_issue_trd)) ||
                       (block_vld && (block_trd == r_issue_trd));

  rr_arb #(
    .N (NUM_TRD),
    .W (TRD_W)
  ) u_rr_arb (
    .i_req     (w_elig),
    .i_ptr     (r_ptr),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_idx (w_gnt_idx)
  );

  for (genvar g = 0; g < NUM_TRD; g++) begin : g_trd
    localparam trd_state_t RST_STATE = (g == 0) ? READY : OFF;

    trd_state_t       r_state;
    trd_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_kill;
    logic             w_block;
    logic             w_wake;
    logic             w_spawn;
    logic             w_win;

    assign w_kill  = kill_vld  && (kill_trd  == TRD_W'(g));
    assign w_block = block_vld && (block_trd == TRD_W'(g));
    assign w_wake  = wake_vld  && (wake_trd  == TRD_W'(g));
    assign w_spawn = spawn_vld && (spawn_trd == TRD_W'(g));
    assign w_win   = w_issue && (w_gnt_idx == TRD_W'(g));

    assign w_elig[g]       = (r_state == READY) && (r_cnt == '0);
    assign w_active_nxt[g] = (w_state_nxt != OFF);

    // Cooldown and issue first; events then override in kill > block > wake > spawn order
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = (r_cnt != '0) ? r_cnt - 1'b1 : '0;
      if ((r_state == COOL) && (r_cnt <= CNT_W'(1))) begin
        w_state_nxt = READY;
      end
      if (w_win && (GAP > 1)) begin
        w_state_nxt = COOL;
        w_cnt_nxt   = COOL_INIT;
      end
      if (w_kill) begin
        w_state_nxt = OFF;
        w_cnt_nxt   = '0;
      end else if (w_block) begin
        if (r_state != OFF) begin
          w_state_nxt = BLOCKED;
        end
      end else if (w_wake) begin
        if (r_state == BLOCKED) begin
          w_state_nxt = READY;
          w_cnt_nxt   = '0;
        end
      end else if (w_spawn) begin
        if (r_state == OFF) begin
          w_state_nxt = READY;
          w_cnt_nxt   = '0;
        end
      end
    end

    // Per-thread state and cooldown counter
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= RST_STATE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end
  end

  // Issue register and round-robin pointer; both freeze under stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_vld <= 1'b0;
      r_issue_trd <= '0;
      r_ptr       <= TRD_W'(NUM_TRD - 1);
    end else if (stall) begin
      if (w_drop_held) begin
        r_issue_vld <= 1'b0;
      end
    end else if (w_gnt_vld) begin
      r_issue_vld <= 1'b1;
      r_issue_trd <= w_gnt_idx;
      r_ptr       <= w_gnt_idx;
    end else begin
      r_issue_vld <= 1'b0;
    end
  end

  // Registered occupancy view of the post-edge thread states
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= NUM_TRD'(1);
      r_idle   <= 1'b0;
    end else begin
      r_active <= w_active_nxt;
      r_idle   <= ~|w_active_nxt;
    end
  end

  assign issue_vld   = r_issue_vld;
  assign issue_trd   = r_issue_trd;
  assign active_mask = r_active;
  assign idle        = r_idle;

endmodule
